rob_mw: RTL and testbench

//   Parametrised reorder buffer, successor to the single-retire ROB: configurable depth, CDB_PORTS completion

---
 rtl/rob_pkg.sv | 34 +++
 rtl/rob_retire_sel.sv | 39 +++
 rtl/rob_mw.sv | 175 +++++++++++++++++
 tb/tb_rob_mw.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the multi-retire reorder buffer (rob_mw). The entry struct fixes the tag widths,
// so PREG_W/AREG_W on rob_mw should stay at the ENT_* values below.
package rob_pkg;

    localparam int ROB_DEPTH_DEF = 32;
    localparam int IDX_W         = $clog2(ROB_DEPTH_DEF);
    localparam int HT_W          = IDX_W + 1;
    localparam int ENT_PREG_W    = 6;
    localparam int ENT_AREG_W    = 5;

    typedef struct packed {
        logic [ENT_PREG_W-1:0] T;
        logic [ENT_PREG_W-1:0] Told;
        logic [ENT_AREG_W-1:0] logic_dest;
        logic [63:0]           PC;
        logic                  br_flag;
        logic                  br_pretaken;
        logic                  br_taken;
        logic [63:0]           br_target;
        logic                  valid;
        logic                  done;
    } rob_entry_t;

    typedef struct packed {
        logic [ENT_PREG_W-1:0] T;
        logic [ENT_PREG_W-1:0] Told;
        logic [ENT_AREG_W-1:0] logic_dest;
    } retire_slot_t;

    function automatic logic is_mispredict(input rob_entry_t e);
        return e.valid && e.done && e.br_flag && (e.br_taken != e.br_pretaken);
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Combinational retire selection: in-order ready chain over the head window, slot-0 mispredict
// detection with recovery PC, and the number of leading accepted slots.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int RETIRE_W = 2,
    parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
    input  rob_entry_t [RETIRE_W-1:0] window,
    input  logic [RETIRE_W-1:0]       retire_en,
    output logic [RETIRE_W-1:0]       retire_rdy,
    output logic                      mispredict,
    output logic [CNT_W-1:0]          retire_cnt,
    output logic [63:0]               recovery_pc
);

    // NOTE: every output and temporary gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        logic chain_ok;
        logic take;
        retire_rdy  = '0;
        retire_cnt  = '0;
        recovery_pc = '0;
        chain_ok    = 1'b1;
        take        = 1'b1;
        for (int k = 0; k < RETIRE_W; k++) begin
            retire_rdy[k] = chain_ok && window[k].valid && window[k].done;
            // A mispredicted branch may itself retire but blocks every younger slot.
            chain_ok      = retire_rdy[k] && !is_mispredict(window[k]);
            take          = take && retire_rdy[k] && retire_en[k];
            retire_cnt    = retire_cnt + CNT_W'(take);
        end
        mispredict = retire_rdy[0] && is_mispredict(window[0]);
        if (mispredict) begin
            recovery_pc = window[0].br_taken ? window[0].br_target : window[0].PC + 64'd4;
        end
    end

endmodule

// File: rtl/rob_mw.sv
// Reorder buffer with CDB_PORTS completion ports and up to RETIRE_W in-order retirements per cycle.
// Define ROB_DEBUG_EN to export head/tail pointers and per-entry state for benches.
module rob_mw
    import rob_pkg::*;
#(
    parameter int  ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int  PREG_W    = ENT_PREG_W,
    parameter int  AREG_W    = ENT_AREG_W,
    parameter int  CDB_PORTS = 2,
    parameter int  RETIRE_W  = 2,
    localparam int ADDR_W    = $clog2(ROB_DEPTH),
    localparam int PTR_W     = ADDR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dispatch_en_i,
    input  logic [PREG_W-1:0]             fl2rob_tag_i,
    input  logic [PREG_W-1:0]             map2rob_tag_i,
    input  logic [AREG_W-1:0]             decode2rob_logic_dest_i,
    input  logic [63:0]                   decode2rob_PC_i,
    input  logic                          decode2rob_br_flag_i,
    input  logic                          decode2rob_br_pretaken_i,
    input  logic [63:0]                   decode2rob_br_target_i,
    input  logic [CDB_PORTS-1:0]          fu_done_i,
    input  logic [CDB_PORTS*ADDR_W-1:0]   fu2rob_idx_i,
    input  logic [CDB_PORTS-1:0]          fu2rob_br_taken_i,
    input  logic [RETIRE_W-1:0]           retire_en_i,
    output logic [ADDR_W-1:0]             rob2rs_tail_idx_o,
    output logic                          rob_full_o,
    output logic                          rob_empty_o,
    output logic [RETIRE_W-1:0]           retire_rdy_o,
    output logic [RETIRE_W*PREG_W-1:0]    retire_tag_o,
    output logic [RETIRE_W*PREG_W-1:0]    retire_told_o,
    output logic [RETIRE_W*AREG_W-1:0]    retire_logic_dest_o,
`ifdef ROB_DEBUG_EN
    output logic [PTR_W-1:0]              head_o,
    output logic [PTR_W-1:0]              tail_o,
    output logic [ROB_DEPTH-1:0]          done_o,
    output logic [ROB_DEPTH-1:0]          valid_o,
    output logic [ROB_DEPTH*PREG_W-1:0]   T_o,
    output logic [ROB_DEPTH*PREG_W-1:0]   Told_o,
`endif
    output logic                          br_recovery_o,
    output logic [63:0]                   br_recovery_pc_o
);

    localparam int CNT_W = $clog2(RETIRE_W + 1);

    logic [PTR_W-1:0]          head_q, tail_q, count;
    logic [ROB_DEPTH-1:0]      valid_q, done_q, taken_q;
    rob_entry_t                mem [ROB_DEPTH];
    rob_entry_t [RETIRE_W-1:0] window;
    logic [ADDR_W-1:0]         win_idx [RETIRE_W];
    retire_slot_t              slots [RETIRE_W];
    logic                      mispredict, do_dispatch, do_flush;
    logic [CNT_W-1:0]          retire_cnt;
    logic [ADDR_W-1:0]         tail_idx;

    assign count             = tail_q - head_q;
    assign rob_full_o        = (count == PTR_W'(ROB_DEPTH));
    assign rob_empty_o       = (count == '0);
    assign tail_idx          = tail_q[ADDR_W-1:0];
    assign rob2rs_tail_idx_o = tail_idx;
    assign do_dispatch       = dispatch_en_i && !rob_full_o;
    assign do_flush          = mispredict && retire_en_i[0];
    assign br_recovery_o     = mispredict;

    // Head window: payload from the array, status from the resettable flag vectors.
    always_comb begin
        for (int k = 0; k < RETIRE_W; k++) begin
            win_idx[k]           = ADDR_W'(head_q + PTR_W'(k));
            window[k]            = mem[win_idx[k]];
            window[k].valid      = valid_q[win_idx[k]];
            window[k].done       = done_q[win_idx[k]];
            window[k].br_taken   = taken_q[win_idx[k]];
        end
    end

    rob_retire_sel #(
        .RETIRE_W (RETIRE_W),
        .CNT_W    (CNT_W)
    ) u_retire_sel (
        .window      (window),
        .retire_en   (retire_en_i),
        .retire_rdy  (retire_rdy_o),
        .mispredict  (mispredict),
        .retire_cnt  (retire_cnt),
        .recovery_pc (br_recovery_pc_o)
    );

    always_comb begin
        retire_tag_o        = '0;
        retire_told_o       = '0;
        retire_logic_dest_o = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            slots[k] = '0;
            if (window[k].valid) begin
                slots[k] = '{T: window[k].T, Told: window[k].Told, logic_dest: window[k].logic_dest};
            end
            retire_tag_o[k*PREG_W +: PREG_W]        = PREG_W'(slots[k].T);
            retire_told_o[k*PREG_W +: PREG_W]       = PREG_W'(slots[k].Told);
            retire_logic_dest_o[k*AREG_W +: AREG_W] = AREG_W'(slots[k].logic_dest);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            taken_q <= '0;
        end else if (do_flush) begin
            // The mispredicted branch retires; everything younger is squashed.
            valid_q <= '0;
            done_q  <= '0;
            taken_q <= '0;
            head_q  <= head_q + PTR_W'(1);
            tail_q  <= head_q + PTR_W'(1);
        end else begin
            if (do_dispatch) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                taken_q[tail_idx] <= 1'b0;
                tail_q            <= tail_q + PTR_W'(1);
            end
            // Walk ports high to low so the lowest port's br_taken lands last and wins.
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (fu_done_i[p] && valid_q[fu2rob_idx_i[p*ADDR_W +: ADDR_W]]) begin
                    done_q[fu2rob_idx_i[p*ADDR_W +: ADDR_W]]  <= 1'b1;
                    taken_q[fu2rob_idx_i[p*ADDR_W +: ADDR_W]] <= fu2rob_br_taken_i[p];
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (k < int'(retire_cnt)) begin
                    valid_q[win_idx[k]] <= 1'b0;
                    done_q[win_idx[k]]  <= 1'b0;
                end
            end
            head_q <= head_q + PTR_W'(retire_cnt);
        end
    end

    // NOTE: the payload array has no reset; valid_q gates every use, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (rst && do_dispatch && !do_flush) begin
            mem[tail_idx] <= '{T:           ENT_PREG_W'(fl2rob_tag_i),
                               Told:        ENT_PREG_W'(map2rob_tag_i),
                               logic_dest:  ENT_AREG_W'(decode2rob_logic_dest_i),
                               PC:          decode2rob_PC_i,
                               br_flag:     decode2rob_br_flag_i,
                               br_pretaken: decode2rob_br_pretaken_i,
                               br_taken:    1'b0,
                               br_target:   decode2rob_br_target_i,
                               valid:       1'b0,
                               done:        1'b0};
        end
    end

`ifdef ROB_DEBUG_EN
    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign done_o  = done_q;
    assign valid_o = valid_q;
    always_comb begin
        T_o    = '0;
        Told_o = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            T_o[i*PREG_W +: PREG_W]    = PREG_W'(mem[i].T);
            Told_o[i*PREG_W +: PREG_W] = PREG_W'(mem[i].Told);
        end
    end
`endif

endmodule

// File: tb/tb_rob_mw.sv
// Directed bench for rob_mw: a queue-based ROB model checked every cycle, plus hand-computed spot checks.
module tb_rob_mw;
    import rob_pkg::*;

    localparam int DEPTH = ROB_DEPTH_DEF;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                dispatch_en;
    logic [5:0]          fl_tag, map_tag;
    logic [4:0]          ldest;
    logic [63:0]         pc, tgt;
    logic                br, pre;
    logic [1:0]          fu_done, fu_taken, ret_en;
    logic [2*IDX_W-1:0]  fu_idx;
    logic [IDX_W-1:0]    tail_idx;
    logic                full, empty, rec;
    logic [1:0]          rdy;
    logic [11:0]         tag, told;
    logic [9:0]          ld;
    logic [63:0]         rec_pc;

    int  checks   = 0;
    int  failures = 0;
    bit  cmp_en   = 1'b0;

    rob_mw dut (
        .clk                      (clk),
        .rst                      (rst),
        .dispatch_en_i            (dispatch_en),
        .fl2rob_tag_i             (fl_tag),
        .map2rob_tag_i            (map_tag),
        .decode2rob_logic_dest_i  (ldest),
        .decode2rob_PC_i          (pc),
        .decode2rob_br_flag_i     (br),
        .decode2rob_br_pretaken_i (pre),
        .decode2rob_br_target_i   (tgt),
        .fu_done_i                (fu_done),
        .fu2rob_idx_i             (fu_idx),
        .fu2rob_br_taken_i        (fu_taken),
        .retire_en_i              (ret_en),
        .rob2rs_tail_idx_o        (tail_idx),
        .rob_full_o               (full),
        .rob_empty_o              (empty),
        .retire_rdy_o             (rdy),
        .retire_tag_o             (tag),
        .retire_told_o            (told),
        .retire_logic_dest_o      (ld),
        .br_recovery_o            (rec),
        .br_recovery_pc_o         (rec_pc)
    );

    always #5 clk = ~clk;

    // ROB model: q[0] is the oldest live instruction, m_head the ROB slot it sits in.
    typedef struct {
        logic [5:0]  t, told;
        logic [4:0]  ld;
        logic [63:0] pc, tgt;
        bit          br, pre, taken, done;
    } ment_t;

    ment_t            q[$];
    logic [HT_W-1:0]  m_head;

    function automatic bit wrong_path(input ment_t e);
        return e.br && e.done && (e.taken != e.pre);
    endfunction

    function automatic logic [1:0] exp_rdy();
        logic [1:0] r = '0;
        for (int k = 0; k < 2; k++) begin
            if (k < q.size()) begin
                r[k] = q[k].done && (k == 0 || (r[k-1] && !wrong_path(q[k-1])));
            end
        end
        return r;
    endfunction

    function automatic bit exp_mp();
        return q.size() > 0 && q[0].done && wrong_path(q[0]);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [1:0]       r;
        int               n;
        logic [IDX_W-1:0] pos;
        if (!rst) begin
            q.delete();
            m_head = '0;
        end else begin
            r = exp_rdy();
            if (exp_mp() && ret_en[0]) begin
                q.delete();
                m_head = m_head + 1'b1;
            end else begin
                for (int p = 1; p >= 0; p--) begin
                    pos = fu_idx[p*IDX_W +: IDX_W] - m_head[IDX_W-1:0];
                    if (fu_done[p] && int'(pos) < q.size()) begin
                        q[pos].done  = 1'b1;
                        q[pos].taken = fu_taken[p];
                    end
                end
                n = 0;
                for (int k = 0; k < 2; k++) if (n == k && r[k] && ret_en[k]) n++;
                if (dispatch_en && q.size() < DEPTH)
                    q.push_back('{t: fl_tag, told: map_tag, ld: ldest, pc: pc, tgt: tgt,
                                  br: br, pre: pre, taken: 1'b0, done: 1'b0});
                repeat (n) void'(q.pop_front());
                m_head = m_head + HT_W'(n);
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0]  r;
        logic [63:0] epc;
        if (cmp_en) begin
            r   = exp_rdy();
            epc = '0;
            if (exp_mp()) epc = q[0].taken ? q[0].tgt : q[0].pc + 64'd4;
            check("full", full, q.size() == DEPTH);
            check("empty", empty, q.size() == 0);
            check("tail_idx", tail_idx, IDX_W'(m_head + HT_W'(q.size())));
            check("retire_rdy", rdy, r);
            check("br_recovery", rec, exp_mp());
            check("recovery_pc", rec_pc, epc);
            for (int k = 0; k < 2; k++) begin
                if (r[k]) begin
                    check($sformatf("tag[%0d]", k), tag[k*6 +: 6], q[k].t);
                    check($sformatf("told[%0d]", k), told[k*6 +: 6], q[k].told);
                    check($sformatf("ldest[%0d]", k), ld[k*5 +: 5], q[k].ld);
                end
            end
        end
    end

    task automatic clear();
        dispatch_en = 1'b0; fl_tag = '0; map_tag = '0; ldest = '0; pc = '0; tgt = '0;
        br = 1'b0; pre = 1'b0; fu_done = '0; fu_idx = '0; fu_taken = '0; ret_en = '0;
    endtask

    task automatic disp(input logic [5:0] t, input logic [5:0] to, input logic [4:0] l,
                        input logic [63:0] p, input logic b, input logic pt, input logic [63:0] tg);
        dispatch_en = 1'b1; fl_tag = t; map_tag = to; ldest = l; pc = p; br = b; pre = pt; tgt = tg;
    endtask

    task automatic complete(input int port, input int idx, input logic taken);
        fu_done[port]                = 1'b1;
        fu_idx[port*IDX_W +: IDX_W]  = IDX_W'(idx);
        fu_taken[port]               = taken;
    endtask

    task automatic half(); @(negedge clk); endtask
    task automatic cyc();  @(posedge clk); #2; clear(); endtask
    task automatic step(); half(); cyc(); endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear();
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1; cmp_en = 1'b1;
        half();
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        check("reset_rdy", rdy, 0);
        cyc();

        for (int i = 0; i < 32; i++) begin
            disp(6'(32 + i), 6'(i), 5'(i), 64'h1000 + 64'(4 * i), i == 4, 1'b0, 64'hABC0);
            step();
        end
        disp(6'd7, 6'd7, 5'd7, 64'h9999, 1'b0, 1'b0, 64'h0);
        half();
        check("full_after_32", full, 1);
        check("tail_wrapped", tail_idx, 0);
        cyc();
        half();
        check("dispatch_33_dropped", full, 1);
        cyc();

        complete(0, 1, 1'b0); complete(1, 0, 1'b0); step();
        ret_en = 2'b01; disp(6'd9, 6'd9, 5'd9, 64'h8888, 1'b0, 1'b0, 64'h0);
        half();
        check("both_ready", rdy, 2'b11);
        check("slot0_tag", tag[5:0], 32);
        check("slot1_tag", tag[11:6], 33);
        cyc();
        ret_en = 2'b01;
        half();
        check("full_retire_drop_full", full, 0);
        check("full_retire_drop_tail", tail_idx, 0);
        check("head1_rdy", rdy, 2'b01);
        cyc();

        complete(0, 3, 1'b0); step();
        half();
        check("in_order_block", rdy, 2'b00);
        cyc();
        complete(0, 2, 1'b0); step();
        ret_en = 2'b10;
        half();
        check("idx2_ready", rdy, 2'b11);
        cyc();
        ret_en = 2'b11;
        half();
        check("gap_ignored", rdy, 2'b11);
        check("idx2_tag", tag[5:0], 34);
        check("idx3_told", told[11:6], 3);
        cyc();

        complete(0, 5, 1'b0); complete(1, 6, 1'b0); step();
        complete(0, 7, 1'b0); complete(1, 8, 1'b0); step();
        complete(0, 9, 1'b0); step();
        half();
        check("branch_pending", rdy, 2'b00);
        cyc();
        complete(0, 4, 1'b1); step();
        half();
        check("mispredict_flag", rec, 1);
        check("mispredict_target", rec_pc, 64'hABC0);
        check("younger_blocked", rdy, 2'b01);
        cyc();
        ret_en = 2'b01; complete(1, 10, 1'b0);
        disp(6'd11, 6'd11, 5'd11, 64'h7777, 1'b0, 1'b0, 64'h0);
        half();
        check("recovery_held", rec, 1);
        cyc();
        half();
        check("flush_empty", empty, 1);
        check("flush_tail", tail_idx, 5);
        check("flush_rec_clear", rec, 0);
        cyc();

        for (int i = 0; i < 10; i++) begin
            disp(6'(i), 6'(i + 10), 5'(i + 1), 64'h2000 + 64'(4 * i), i == 0, 1'b1, 64'h3000);
            step();
        end
        complete(0, 5, 1'b0); step();
        half();
        check("not_taken_recovery", rec, 1);
        check("not_taken_pc", rec_pc, 64'h2004);
        cyc();

        rst = 1'b0; ret_en = 2'b01;
        complete(0, 6, 1'b0); complete(1, 7, 1'b1);
        disp(6'd12, 6'd12, 5'd12, 64'h6666, 1'b0, 1'b0, 64'h0);
        step();
        rst = 1'b1;
        half();
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        check("midrst_tail", tail_idx, 0);
        check("midrst_rdy", rdy, 0);
        check("midrst_rec", rec, 0);
        check("midrst_pc", rec_pc, 0);
        check("midrst_tag", tag, 0);
        check("midrst_told", told, 0);
        check("midrst_ldest", ld, 0);
        cyc();
        step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
